// File: rtl/sd_spi_card_responder.sv
// SPI-mode SD card stand-in: decodes CMD17/CMD24, streams 512-byte sectors from an internal
// store and accepts sector writes into it. Control advances on rising CLK, DO updates on falling.
module sd_spi_card_responder #(
    parameter int unsigned SECTORS     = 4,
    parameter int unsigned NCR_BYTES   = 1,
    parameter int unsigned NAC_BYTES   = 1,
    parameter int unsigned BUSY_CYCLES = 16
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       cs_ni,
    input  logic       di_i,
    output logic       do_o,
    output logic       busy_o,
    output logic [5:0] last_cmd_o,
    output logic       write_done_o,
    output logic       cmd_error_o
);
    localparam int unsigned SecW  = (SECTORS > 1) ? $clog2(SECTORS) : 1;
    localparam int unsigned Depth = SECTORS * 512;
    localparam int unsigned AddrW = $clog2(Depth);
    localparam logic [15:0] NcrLast  = 16'(8 * NCR_BYTES - 1);
    localparam logic [15:0] NacLast  = 16'(8 * NAC_BYTES - 1);
    localparam logic [15:0] BusyLast = 16'(BUSY_CYCLES - 1);
    localparam logic [7:0]  RdTok    = 8'hFE;
    localparam logic [7:0]  WrResp   = 8'hE5;

    typedef enum logic [3:0] {
        StCmdWait, StCmdShift, StNcr, StR1Send, StNac, StRdToken, StRdData,
        StRdCrc, StWrHunt, StWrData, StWrCrc, StWrResp, StWrBusy
    } state_e;

    state_e            state_q, state_d;
    logic [15:0]       bit_cnt_q, bit_cnt_d;
    logic [8:0]        byte_idx_q, byte_idx_d;
    logic [44:0]       cmd_sr_q, cmd_sr_d;
    logic [7:0]        r1_q, r1_d;
    logic              is_read_q, is_read_d;
    logic [SecW-1:0]   sec_q, sec_d;
    logic [6:0]        wr_sr_q, wr_sr_d;
    logic [5:0]        last_cmd_q, last_cmd_d;
    logic              write_done_q, write_done_d;
    logic              cmd_error_q, cmd_error_d;
    logic              do_q, do_d;
    logic              mem_we;
    logic [31:0]       arg;
    logic [AddrW-1:0]  addr;
    logic [7:0]        pattern, rd_byte;

    // Store holds data XOR the power-up pattern, so an all-zero array reads back (i+s) mod 256.
    logic [7:0] mem_q [Depth] = '{default: 8'h00};

    assign arg     = cmd_sr_q[38:7];
    assign addr    = AddrW'({sec_q, byte_idx_q});
    assign pattern = byte_idx_q[7:0] + 8'(sec_q);
    assign rd_byte = mem_q[addr] ^ pattern;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q + 16'd1;
        byte_idx_d   = byte_idx_q;
        cmd_sr_d     = cmd_sr_q;
        r1_d         = r1_q;
        is_read_d    = is_read_q;
        sec_d        = sec_q;
        wr_sr_d      = wr_sr_q;
        last_cmd_d   = last_cmd_q;
        write_done_d = 1'b0;
        cmd_error_d  = 1'b0;
        mem_we       = 1'b0;
        if (cs_ni) begin
            state_d    = StCmdWait;
            bit_cnt_d  = '0;
            byte_idx_d = '0;
        end else begin
            case (state_q)
                StCmdWait: begin
                    bit_cnt_d = '0;
                    if (!di_i) state_d = StCmdShift;
                end
                StCmdShift: begin
                    cmd_sr_d = {cmd_sr_q[43:0], di_i};
                    if (bit_cnt_q == 16'd0 && !di_i) begin
                        state_d   = StCmdWait;
                        bit_cnt_d = '0;
                    end else if (bit_cnt_q == 16'd46) begin
                        last_cmd_d = cmd_sr_q[44:39];
                        is_read_d  = (cmd_sr_q[44:39] == 6'd17);
                        sec_d      = arg[SecW-1:0];
                        if (cmd_sr_q[44:39] == 6'd17 || cmd_sr_q[44:39] == 6'd24) begin
                            r1_d = (arg < 32'(SECTORS)) ? 8'h00 : 8'h20;
                        end else begin
                            r1_d = 8'h04;
                        end
                        state_d   = StNcr;
                        bit_cnt_d = '0;
                    end
                end
                StNcr: if (bit_cnt_q == NcrLast) begin
                    state_d   = StR1Send;
                    bit_cnt_d = '0;
                end
                StR1Send: if (bit_cnt_q == 16'd7) begin
                    bit_cnt_d  = '0;
                    byte_idx_d = '0;
                    if (r1_q != 8'h00) begin
                        state_d     = StCmdWait;
                        cmd_error_d = 1'b1;
                    end else begin
                        state_d = is_read_q ? StNac : StWrHunt;
                    end
                end
                StNac: if (bit_cnt_q == NacLast) begin
                    state_d   = StRdToken;
                    bit_cnt_d = '0;
                end
                StRdToken: if (bit_cnt_q == 16'd7) begin
                    state_d   = StRdData;
                    bit_cnt_d = '0;
                end
                StRdData: if (bit_cnt_q == 16'd7) begin
                    bit_cnt_d = '0;
                    if (byte_idx_q == 9'd511) state_d = StRdCrc;
                    else byte_idx_d = byte_idx_q + 9'd1;
                end
                StRdCrc: if (bit_cnt_q == 16'd15) begin
                    state_d   = StCmdWait;
                    bit_cnt_d = '0;
                end
                StWrHunt: begin
                    bit_cnt_d = '0;
                    if (!di_i) state_d = StWrData;
                end
                StWrData: begin
                    wr_sr_d = {wr_sr_q[5:0], di_i};
                    if (bit_cnt_q == 16'd7) begin
                        mem_we    = 1'b1;
                        bit_cnt_d = '0;
                        if (byte_idx_q == 9'd511) state_d = StWrCrc;
                        else byte_idx_d = byte_idx_q + 9'd1;
                    end
                end
                StWrCrc: if (bit_cnt_q == 16'd15) begin
                    state_d   = StWrResp;
                    bit_cnt_d = '0;
                end
                StWrResp: if (bit_cnt_q == 16'd7) begin
                    state_d   = StWrBusy;
                    bit_cnt_d = '0;
                end
                StWrBusy: if (bit_cnt_q == BusyLast) begin
                    state_d      = StCmdWait;
                    bit_cnt_d    = '0;
                    write_done_d = 1'b1;
                end
                default: begin
                    state_d   = StCmdWait;
                    bit_cnt_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        do_d = 1'b1;
        case (state_q)
            StR1Send:  do_d = r1_q[~bit_cnt_q[2:0]];
            StRdToken: do_d = RdTok[~bit_cnt_q[2:0]];
            StRdData:  do_d = rd_byte[~bit_cnt_q[2:0]];
            StWrResp:  do_d = WrResp[~bit_cnt_q[2:0]];
            StWrBusy:  do_d = 1'b0;
            default:   do_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= StCmdWait;
            bit_cnt_q    <= '0;
            byte_idx_q   <= '0;
            cmd_sr_q     <= '0;
            r1_q         <= '0;
            is_read_q    <= 1'b0;
            sec_q        <= '0;
            wr_sr_q      <= '0;
            last_cmd_q   <= '0;
            write_done_q <= 1'b0;
            cmd_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_idx_q   <= byte_idx_d;
            cmd_sr_q     <= cmd_sr_d;
            r1_q         <= r1_d;
            is_read_q    <= is_read_d;
            sec_q        <= sec_d;
            wr_sr_q      <= wr_sr_d;
            last_cmd_q   <= last_cmd_d;
            write_done_q <= write_done_d;
            cmd_error_q  <= cmd_error_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we && !reset_i) mem_q[addr] <= {wr_sr_q, di_i} ^ pattern;
    end

    always_ff @(negedge clk_i) begin
        if (reset_i) do_q <= 1'b1;
        else         do_q <= do_d;
    end

    assign do_o         = do_q;
    assign busy_o       = !cs_ni && (state_q != StCmdWait);
    assign last_cmd_o   = last_cmd_q;
    assign write_done_o = write_done_q;
    assign cmd_error_o  = cmd_error_q;
endmodule
